// File: rtl/keep_budget_pkg.sv
// keep_budget_pkg
// Shared types and helpers for the keep-qualified byte-budget gate.
//   gate_mode_e      : TRIM (clear excess kept bytes) / STALL (backpressure until credit fits)
//   BW               : credit/budget width for the default BUDGETMAX
//   popcount()       : number of set bits in a keep mask (zero-extended to POP_MAXW)
package keep_budget_pkg;

    localparam int BUSBYTEWIDTH_DEF = 16;
    localparam int BUDGETMAX_DEF    = 32;
    localparam int BW               = $clog2(BUDGETMAX_DEF + 1);

    // Widest keep mask the popcount helper accepts; narrower masks are zero-extended.
    localparam int POP_MAXW = 256;

    typedef enum logic {
        TRIM  = 1'b0,
        STALL = 1'b1
    } gate_mode_e;

    function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAXW; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keep_budget_gate_trim.sv
// keep_prefix_trim
// Combinational prefix trim of a keep mask against a byte limit.
//   keep     in  : keep mask, bit i qualifies byte i
//   limit    in  : number of bytes allowed through
//   keep_out out : keep with only the lowest-order `limit` set bits retained
//   n        out : popcount(keep)
//   over     out : n > limit
module keep_prefix_trim
    import keep_budget_pkg::*;
#(
    parameter int KW = 16,
    parameter int LW = 6
) (
    input  logic [KW-1:0]            keep,
    input  logic [LW-1:0]            limit,
    output logic [KW-1:0]            keep_out,
    output logic [$clog2(KW+1)-1:0]  n,
    output logic                     over
);

    localparam int NW = $clog2(KW + 1);
    localparam int CW = ((NW > LW) ? NW : LW) + 1;

    // Running count of set keep bits; a bit survives while the count is within the limit.
    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        keep_out = '0;
        for (int i = 0; i < KW; i++) begin
            acc         = acc + CW'(keep[i]);
            keep_out[i] = keep[i] && (acc <= CW'(limit));
        end
    end

    assign n    = NW'(popcount(POP_MAXW'(keep)));
    assign over = CW'(n) > CW'(limit);

endmodule

// File: rtl/keep_budget_gate.sv
// keep_budget_gate
// Two-stage byte-budget gate on a keep-qualified stream. S1 holds the beat
// under decision, S2 is the output register. Kept bytes consume credit; the
// downstream store returns credit via credit_vld/credit_bytes.
//   clk, reset_n                     : clock, async active-low reset
//   mode                             : 0 = TRIM, 1 = STALL (sampled when a beat fires)
//   credit_vld, credit_bytes         : credit return
//   businvld/businrdy/businkeep/busin/businlast       : input beat
//   busoutvld/busoutrdy/busoutkeep/busout/busoutlast  : output beat
//   budget                           : current credit in bytes
//   drop_pulse, dropcnt              : drop event / saturating dropped-byte count
//   credit_err                       : sticky, credit return overflowed BUDGETMAX
module keep_budget_gate
    import keep_budget_pkg::*;
#(
    parameter int BUSBYTEWIDTH = 16,
    parameter int BUDGETMAX    = 32,
    parameter int CNTW         = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               mode,
    input  logic                               credit_vld,
    input  logic [$clog2(BUDGETMAX+1)-1:0]     credit_bytes,
    input  logic                               businvld,
    output logic                               businrdy,
    input  logic [BUSBYTEWIDTH-1:0]            businkeep,
    input  logic [BUSBYTEWIDTH*8-1:0]          busin,
    input  logic                               businlast,
    output logic                               busoutvld,
    input  logic                               busoutrdy,
    output logic [BUSBYTEWIDTH-1:0]            busoutkeep,
    output logic [BUSBYTEWIDTH*8-1:0]          busout,
    output logic                               busoutlast,
    output logic [$clog2(BUDGETMAX+1)-1:0]     budget,
    output logic                               drop_pulse,
    output logic [CNTW-1:0]                    dropcnt,
    output logic                               credit_err
);

    localparam int KW = BUSBYTEWIDTH;
    localparam int DW = BUSBYTEWIDTH * 8;
    localparam int LW = $clog2(BUDGETMAX + 1);
    localparam int NW = $clog2(KW + 1);
    // Wide enough for budget + credit (each < 2^LW) without wrap.
    localparam int CW = ((NW > LW) ? NW : LW) + 1;

    logic            s1_vld, s1_last;
    logic [KW-1:0]   s1_keep;
    logic [DW-1:0]   s1_data;
    logic            s2_vld, s2_last;
    logic [KW-1:0]   s2_keep;
    logic [DW-1:0]   s2_data;

    logic [KW-1:0]   trim_keep;
    logic [NW-1:0]   n;
    logic            over;
    logic            never_fits;
    logic            s2_adv;
    logic            fire;
    logic            accept;
    logic [CW-1:0]   n_w, b_w, consumed, dropped, credit_w, bud_sum;
    logic [CNTW:0]   drop_sum;

    keep_prefix_trim #(
        .KW (KW),
        .LW (LW)
    ) u_trim (
        .keep     (s1_keep),
        .limit    (budget),
        .keep_out (trim_keep),
        .n        (n),
        .over     (over)
    );

    assign n_w        = CW'(n);
    assign b_w        = CW'(budget);
    // A beat wider than the whole budget can never fit; trimming it avoids deadlock in STALL.
    assign never_fits = n_w > CW'(BUDGETMAX);
    assign s2_adv     = !s2_vld || busoutrdy;
    assign fire       = s1_vld && s2_adv &&
                        (gate_mode_e'(mode) == TRIM || !over || never_fits);
    assign businrdy   = !s1_vld || fire;
    assign accept     = businvld && businrdy;

    assign consumed = !fire ? '0 : (over ? b_w : n_w);
    assign dropped  = (fire && over) ? (n_w - b_w) : '0;
    assign credit_w = credit_vld ? CW'(credit_bytes) : '0;
    // Credit arriving this cycle only becomes usable next cycle.
    assign bud_sum  = b_w - consumed + credit_w;
    assign drop_sum = {1'b0, dropcnt} + (CNTW+1)'(dropped);

    assign busoutvld  = s2_vld;
    assign busoutkeep = s2_keep;
    assign busout     = s2_data;
    assign busoutlast = s2_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            s1_keep    <= '0;
            s1_data    <= '0;
            s2_vld     <= 1'b0;
            s2_last    <= 1'b0;
            s2_keep    <= '0;
            s2_data    <= '0;
            budget     <= LW'(BUDGETMAX);
            drop_pulse <= 1'b0;
            dropcnt    <= '0;
            credit_err <= 1'b0;
        end else begin
            if (accept) begin
                s1_vld  <= 1'b1;
                s1_keep <= businkeep;
                s1_data <= busin;
                s1_last <= businlast;
            end else if (fire) begin
                s1_vld  <= 1'b0;
            end

            if (s2_adv) begin
                s2_vld <= fire;
                if (fire) begin
                    s2_keep <= trim_keep;
                    s2_data <= s1_data;
                    s2_last <= s1_last;
                end
            end

            drop_pulse <= fire && over;
            if (fire && over) begin
                dropcnt <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
            end

            if (bud_sum > CW'(BUDGETMAX)) begin
                budget     <= LW'(BUDGETMAX);
                credit_err <= 1'b1;
            end else begin
                budget     <= bud_sum[LW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_keep_budget_gate.sv
module tb_keep_budget_gate;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode;
    logic         credit_vld;
    logic [5:0]   credit_bytes;
    logic         businvld;
    logic         businrdy;
    logic [15:0]  businkeep;
    logic [127:0] busin;
    logic         businlast;
    logic         busoutvld;
    logic         busoutrdy;
    logic [15:0]  busoutkeep;
    logic [127:0] busout;
    logic         busoutlast;
    logic [5:0]   budget;
    logic         drop_pulse;
    logic [15:0]  dropcnt;
    logic         credit_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keep_budget_gate #(
        .BUSBYTEWIDTH (16),
        .BUDGETMAX    (32),
        .CNTW         (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .credit_vld   (credit_vld),
        .credit_bytes (credit_bytes),
        .businvld     (businvld),
        .businrdy     (businrdy),
        .businkeep    (businkeep),
        .busin        (busin),
        .businlast    (businlast),
        .busoutvld    (busoutvld),
        .busoutrdy    (busoutrdy),
        .busoutkeep   (busoutkeep),
        .busout       (busout),
        .busoutlast   (busoutlast),
        .budget       (budget),
        .drop_pulse   (drop_pulse),
        .dropcnt      (dropcnt),
        .credit_err   (credit_err)
    );

    typedef struct {
        int          credit;
        logic [15:0] keep;
        logic        last;
        logic [15:0] exp_keep;
        logic [5:0]  exp_budget;
        logic        exp_drop;
        logic [15:0] exp_dropcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic give_credit(input int c);
        @(negedge clk);
        credit_vld   = 1'b1;
        credit_bytes = 6'(c);
        @(negedge clk);
        credit_vld   = 1'b0;
        credit_bytes = '0;
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send_beat(input logic [15:0] k, input logic [127:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        businvld  = 1'b1;
        businkeep = k;
        busin     = d;
        businlast = l;
        #1;
        while (!businrdy && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!businrdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got businrdy=0 expected 1");
        end
        @(posedge clk);
        #1;
        businvld = 1'b0;
    endtask

    function automatic logic [15:0] lowbits(input logic [15:0] k, input int cnt);
        logic [15:0] r;
        int c;
        r = '0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            if (k[i] && c < cnt) begin
                r[i] = 1'b1;
                c++;
            end
        end
        return r;
    endfunction

    // stream scoreboard state
    localparam int NS = 60;
    logic [15:0]  in_keep_q[$];
    logic [127:0] in_data_q[$];
    logic         in_last_q[$];
    logic [15:0]  ek;
    logic [127:0] ed;
    logic         el;
    int pushes, got, pending, credit_tot, kept_tot, drop_tot, cyc, c, vld_seen;
    logic acc_flag, prev_stall, prev_last;
    logic [15:0]  prev_keep;
    logic [127:0] prev_data;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0,  16'hFFFF, 1'b0, 16'hFFFF, 6'd16, 1'b0, 16'd0};
        vecs[1] = '{0,  16'h07FF, 1'b0, 16'h07FF, 6'd5,  1'b0, 16'd0};
        vecs[2] = '{0,  16'hF0F0, 1'b0, 16'h10F0, 6'd0,  1'b1, 16'd3};
        vecs[3] = '{0,  16'h00FF, 1'b1, 16'h0000, 6'd0,  1'b1, 16'd11};
        vecs[4] = '{20, 16'h0003, 1'b0, 16'h0003, 6'd18, 1'b0, 16'd11};
        vecs[5] = '{0,  16'hFFFF, 1'b1, 16'hFFFF, 6'd2,  1'b0, 16'd11};
        vecs[6] = '{0,  16'h8001, 1'b0, 16'h8001, 6'd0,  1'b0, 16'd11};
        vecs[7] = '{3,  16'h000F, 1'b0, 16'h0007, 6'd0,  1'b1, 16'd12};
        vecs[8] = '{0,  16'h0000, 1'b1, 16'h0000, 6'd0,  1'b0, 16'd12};

        reset_n      = 1'b0;
        mode         = 1'b0;
        credit_vld   = 1'b0;
        credit_bytes = '0;
        businvld     = 1'b0;
        businkeep    = '0;
        busin        = '0;
        businlast    = 1'b0;
        busoutrdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_budget", budget, 6'd32);
        chk("rst_outvld", busoutvld, 1'b0);
        chk("rst_dropcnt", dropcnt, 16'd0);
        chk("rst_credit_err", credit_err, 1'b0);
        chk("rst_inrdy", businrdy, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // TRIM single beats, running budget from reset value
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].credit > 0) give_credit(vecs[i].credit);
            send_beat(vecs[i].keep, {4{32'hA5000000 + 32'(i)}}, vecs[i].last);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i), busoutvld, 1'b1);
            chk($sformatf("v%0d_keep", i), busoutkeep, vecs[i].exp_keep);
            chk($sformatf("v%0d_data", i), busout, {4{32'hA5000000 + 32'(i)}});
            chk($sformatf("v%0d_last", i), busoutlast, vecs[i].last);
            chk($sformatf("v%0d_budget", i), budget, vecs[i].exp_budget);
            chk($sformatf("v%0d_drop", i), drop_pulse, vecs[i].exp_drop);
            chk($sformatf("v%0d_dropcnt", i), dropcnt, vecs[i].exp_dropcnt);
        end
        @(posedge clk);
        #1;
        chk("drop_pulse_one_cycle", drop_pulse, 1'b0);

        // STALL: beat waits until returned credit lands
        give_credit(4);
        mode = 1'b1;
        send_beat(16'h00FF, 128'h1234, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_inrdy", businrdy, 1'b0);
        chk("stall_outvld", busoutvld, 1'b0);
        chk("stall_budget", budget, 6'd4);
        @(negedge clk);
        credit_vld   = 1'b1;
        credit_bytes = 6'd4;
        @(posedge clk);
        #1;
        chk("stall_credit_budget", budget, 6'd8);
        chk("stall_credit_nofire", busoutvld, 1'b0);
        @(negedge clk);
        credit_vld   = 1'b0;
        credit_bytes = '0;
        @(posedge clk);
        #1;
        chk("stall_fire_vld", busoutvld, 1'b1);
        chk("stall_fire_keep", busoutkeep, 16'h00FF);
        chk("stall_fire_budget", budget, 6'd0);
        chk("stall_fire_drop", drop_pulse, 1'b0);

        // mode switch releases a waiting STALL beat as TRIM
        send_beat(16'h0003, 128'h5678, 1'b1);
        @(posedge clk);
        #1;
        chk("sw_wait_inrdy", businrdy, 1'b0);
        chk("sw_wait_vld", busoutvld, 1'b0);
        @(negedge clk);
        mode = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_vld", busoutvld, 1'b1);
        chk("sw_keep", busoutkeep, 16'h0000);
        chk("sw_last", busoutlast, 1'b1);
        chk("sw_drop", drop_pulse, 1'b1);
        chk("sw_dropcnt", dropcnt, 16'd14);

        // credit overflow clamps and sets sticky error
        give_credit(30);
        chk("cr30_budget", budget, 6'd30);
        chk("cr30_err", credit_err, 1'b0);
        give_credit(10);
        chk("cr_clamp_budget", budget, 6'd32);
        chk("cr_clamp_err", credit_err, 1'b1);
        @(posedge clk);
        #1;
        chk("cr_err_sticky", credit_err, 1'b1);

        // async reset clears sticky state without a clock edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_credit_err", credit_err, 1'b0);
        chk("arst_dropcnt", dropcnt, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // random stream with random output backpressure; credit returns what drains
        pushes = 0; got = 0; pending = 0; credit_tot = 0; kept_tot = 0; drop_tot = 0; cyc = 0;
        acc_flag = 1'b0; prev_stall = 1'b0; prev_keep = '0; prev_data = '0; prev_last = 1'b0;
        while (got < NS && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (acc_flag) begin
                businvld = 1'b0;
                acc_flag = 1'b0;
            end
            busoutrdy = ($urandom_range(0, 3) != 0);
            if (pending > 0) begin
                c = (pending > 20) ? 20 : pending;
                pending -= c;
                credit_tot += c;
                credit_vld   = 1'b1;
                credit_bytes = 6'(c);
            end else begin
                credit_vld   = 1'b0;
                credit_bytes = '0;
            end
            if (!businvld && pushes < NS && $urandom_range(0, 4) != 0) begin
                businvld  = 1'b1;
                businkeep = 16'($urandom);
                busin     = {$urandom, $urandom, $urandom, $urandom};
                businlast = 1'($urandom_range(0, 1));
            end
            #1;
            if (prev_stall) begin
                chk("hold_vld", busoutvld, 1'b1);
                chk("hold_keep", busoutkeep, prev_keep);
                chk("hold_data", busout, prev_data);
                chk("hold_last", busoutlast, prev_last);
            end
            if (businvld && businrdy) begin
                in_keep_q.push_back(businkeep);
                in_data_q.push_back(busin);
                in_last_q.push_back(businlast);
                pushes++;
                acc_flag = 1'b1;
            end
            if (busoutvld && busoutrdy) begin
                if (in_keep_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra_beat: got beat expected none");
                end else begin
                    ek = in_keep_q.pop_front();
                    ed = in_data_q.pop_front();
                    el = in_last_q.pop_front();
                    chk("stream_data", busout, ed);
                    chk("stream_last", busoutlast, el);
                    chk("stream_keep_shape", busoutkeep, lowbits(ek, $countones(busoutkeep)));
                    pending  += $countones(busoutkeep);
                    kept_tot += $countones(busoutkeep);
                    drop_tot += $countones(ek) - $countones(busoutkeep);
                end
                got++;
            end
            prev_stall = busoutvld && !busoutrdy;
            prev_keep  = busoutkeep;
            prev_data  = busout;
            prev_last  = busoutlast;
        end
        chk("stream_count", 32'(got), 32'(NS));
        @(negedge clk);
        businvld  = 1'b0;
        busoutrdy = 1'b1;
        while (pending > 0) begin
            c = (pending > 20) ? 20 : pending;
            pending -= c;
            credit_tot += c;
            credit_vld   = 1'b1;
            credit_bytes = 6'(c);
            @(negedge clk);
        end
        credit_vld   = 1'b0;
        credit_bytes = '0;
        repeat (2) @(negedge clk);
        chk("stream_budget", 32'(budget), 32'(32 - kept_tot + credit_tot));
        chk("stream_dropcnt", 32'(dropcnt), 32'(drop_tot));
        chk("stream_credit_err", credit_err, 1'b0);
        chk("stream_left", 32'(in_keep_q.size()), 32'd0);

        // reset while output is held and a STALL beat waits in S1
        mode      = 1'b1;
        busoutrdy = 1'b0;
        send_beat(16'hFFFF, 128'hAAAA, 1'b0);
        send_beat(16'hFFFF, 128'hBBBB, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_outvld", busoutvld, 1'b1);
        chk("pre_rst_inrdy", businrdy, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outvld", busoutvld, 1'b0);
        chk("mid_rst_keep", busoutkeep, 16'h0000);
        chk("mid_rst_data", busout, 128'h0);
        chk("mid_rst_last", busoutlast, 1'b0);
        chk("mid_rst_budget", budget, 6'd32);
        chk("mid_rst_drop", drop_pulse, 1'b0);
        chk("mid_rst_inrdy", businrdy, 1'b1);
        @(negedge clk);
        reset_n   = 1'b1;
        busoutrdy = 1'b1;
        vld_seen  = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (busoutvld) vld_seen++;
        end
        chk("post_rst_no_beat", 32'(vld_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
